control_alu_mdu: RTL and testbench

- Parametrised successor to the execute-stage ALU control decoder.
- Decodes i_alu_op/funct3/funct7 into ALU control and shift type, as before, and adds RV32M support.
- MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU are executed on an iterative multiply/divide sequencer.
- While an M op is in flight, a stall request freezes the pipeline.

---
 rtl/control_alu_mdu_pkg.sv | 54 +++++
 rtl/control_alu_mdu_if.sv | 29 ++
 rtl/control_alu_mdu_mdu_core.sv | 173 +++++++++++++++++
 rtl/control_alu_mdu.sv | 70 +++++++
 tb/tb_control_alu_mdu.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/control_alu_mdu_pkg.sv
// Shared codes for the execute-stage ALU control decoder and the RV32M sequencer.
package control_alu_mdu_pkg;

    localparam logic [2:0] ALU_OP_LS     = 3'b000;
    localparam logic [2:0] ALU_OP_BRANCH = 3'b001;
    localparam logic [2:0] ALU_OP_R      = 3'b010;
    localparam logic [2:0] ALU_OP_I      = 3'b011;
    localparam logic [2:0] ALU_OP_LUI    = 3'b100;

    localparam logic [2:0] ALU_CTL_ADD   = 3'b000;
    localparam logic [2:0] ALU_CTL_SUB   = 3'b001;
    localparam logic [2:0] ALU_CTL_AND   = 3'b010;
    localparam logic [2:0] ALU_CTL_OR    = 3'b011;
    localparam logic [2:0] ALU_CTL_XOR   = 3'b100;
    localparam logic [2:0] ALU_CTL_SLT   = 3'b101;
    localparam logic [2:0] ALU_CTL_SLTU  = 3'b110;
    localparam logic [2:0] ALU_CTL_SHIFT = 3'b111;

    localparam logic [1:0] ALU_SHIFT_NONE = 2'b00;
    localparam logic [1:0] ALU_SHIFT_SLL  = 2'b01;
    localparam logic [1:0] ALU_SHIFT_SRL  = 2'b10;
    localparam logic [1:0] ALU_SHIFT_SRA  = 2'b11;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] MUL_F3    = 3'b000;
    localparam logic [2:0] MULH_F3   = 3'b001;
    localparam logic [2:0] MULHSU_F3 = 3'b010;
    localparam logic [2:0] MULHU_F3  = 3'b011;
    localparam logic [2:0] DIV_F3    = 3'b100;
    localparam logic [2:0] DIVU_F3   = 3'b101;
    localparam logic [2:0] REM_F3    = 3'b110;
    localparam logic [2:0] REMU_F3   = 3'b111;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_MUL  = 2'b01,
        MDU_DIV  = 2'b10,
        MDU_DONE = 2'b11
    } mdu_state_e;

endpackage

// File: rtl/control_alu_mdu_if.sv
// Execute-stage control bus: decode inputs, operands, and the ALU/MDU control outputs.
interface control_alu_mdu_if #(parameter int XLEN = 32);

    logic [2:0]      i_alu_op;
    logic [2:0]      i_f3;
    logic            i_f7_b6;
    logic            i_f7_b0;
    logic            i_valid;
    logic            i_flush;
    logic [XLEN-1:0] i_rs1;
    logic [XLEN-1:0] i_rs2;
    logic [2:0]      o_alu_ctl;
    logic [1:0]      o_alu_shift;
    logic            o_is_mdu;
    logic            o_stall;
    logic            o_mdu_done;
    logic [XLEN-1:0] o_mdu_result;

    modport master (
        output i_alu_op, i_f3, i_f7_b6, i_f7_b0, i_valid, i_flush, i_rs1, i_rs2,
        input  o_alu_ctl, o_alu_shift, o_is_mdu, o_stall, o_mdu_done, o_mdu_result
    );

    modport slave (
        input  i_alu_op, i_f3, i_f7_b6, i_f7_b0, i_valid, i_flush, i_rs1, i_rs2,
        output o_alu_ctl, o_alu_shift, o_is_mdu, o_stall, o_mdu_done, o_mdu_result
    );

endinterface

// File: rtl/control_alu_mdu_mdu_core.sv
// Iterative RV32M sequencer: shift-add multiplier, restoring divider, shared accumulator.
// MDU_FAST_MUL_EN replaces the shift-add loop with a single-cycle multiply.
module mdu_core
    import control_alu_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      f3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [2*XLEN-1:0] neg_wide(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] neg_narrow(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    mdu_state_e        state_q, state_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;

    logic signed [XLEN-1:0] rs1_s, rs2_s;
    logic                   a_signed, b_signed, sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0]        mag_a, mag_b;
    logic [XLEN:0]          mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0]      mul_step, div_step, prod_fix;
    logic [XLEN-1:0]        quo_fix, rem_fix;

    assign rs1_s = rs1;
    assign rs2_s = rs2;

    // Operand classification at issue; special divides bypass the loop entirely.
    assign a_signed = (f3 == MULH_F3) || (f3 == MULHSU_F3) || (f3 == DIV_F3) || (f3 == REM_F3);
    assign b_signed = (f3 == MULH_F3) || (f3 == DIV_F3) || (f3 == REM_F3);
    assign sa       = a_signed && (rs1_s < 0);
    assign sb       = b_signed && (rs2_s < 0);
    assign mag_a    = neg_narrow(rs1, sa);
    assign mag_b    = neg_narrow(rs2, sb);
    assign div_zero = f3[2] && (rs2 == '0);
    assign div_ovf  = f3[2] && !f3[0] && (rs1 == INT_MIN) && (&rs2);

    // Multiply keeps the multiplier in the low half and shifts the partial sum in from the top.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

    // Divide keeps {remainder, quotient}; quotient bits shift in at the bottom.
    assign div_shift = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_step  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                      : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

    assign prod_fix = neg_wide(acc_q, neg_q);
    assign quo_fix  = neg_narrow(acc_q[XLEN-1:0], neg_q);
    assign rem_fix  = neg_narrow(acc_q[2*XLEN-1:XLEN], rneg_q);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        stall   = 1'b0;
        done    = 1'b0;
        result  = '0;
        case (state_q)
            MDU_IDLE: begin
                if (start) begin
                    stall  = 1'b1;
                    f3_d   = f3;
                    cnt_d  = '0;
                    neg_d  = sa ^ sb;
                    rneg_d = sa;
                    if (div_zero) begin
                        acc_d   = {rs1, {XLEN{1'b1}}};
                        neg_d   = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = MDU_DONE;
                    end else if (div_ovf) begin
                        acc_d   = {{XLEN{1'b0}}, rs1};
                        neg_d   = 1'b0;
                        rneg_d  = 1'b0;
                        state_d = MDU_DONE;
                    end else if (f3[2]) begin
                        acc_d   = {{XLEN{1'b0}}, mag_a};
                        opb_d   = mag_b;
                        state_d = MDU_DIV;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, mag_b};
                        opb_d   = mag_a;
                        state_d = MDU_MUL;
                    end
                end
            end
            MDU_MUL: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = MDU_IDLE;
                end else begin
`ifdef MDU_FAST_MUL_EN
                    acc_d   = {{XLEN{1'b0}}, opb_q} * {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
                    state_d = MDU_DONE;
`else
                    acc_d = mul_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = MDU_DONE;
`endif
                end
            end
            MDU_DIV: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = MDU_IDLE;
                end else begin
                    acc_d = div_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = MDU_DONE;
                end
            end
            MDU_DONE: begin
                // The pipeline advances this cycle, so never re-arm from DONE.
                state_d = MDU_IDLE;
                if (!flush) begin
                    done = 1'b1;
                    if (f3_q[2])              result = f3_q[1] ? rem_fix : quo_fix;
                    else if (f3_q == MUL_F3)  result = prod_fix[XLEN-1:0];
                    else                      result = prod_fix[2*XLEN-1:XLEN];
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MDU_IDLE;
            acc_q   <= '0;
            opb_q   <= '0;
            cnt_q   <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
        end
    end

endmodule

// File: rtl/control_alu_mdu.sv
// Execute-stage ALU control decode with RV32M dispatch to the iterative mdu_core.
// Optional build macro: MDU_FAST_MUL_EN (single-cycle multiply inside mdu_core).
module control_alu_mdu
    import control_alu_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    control_alu_mdu_if.slave bus
);

    logic is_mdu;
    logic start;

    assign is_mdu = (bus.i_alu_op == ALU_OP_R) && bus.i_f7_b0;
    assign start  = bus.i_valid && is_mdu && !bus.i_flush;

    always_comb begin
        bus.o_alu_ctl   = ALU_CTL_ADD;
        bus.o_alu_shift = ALU_SHIFT_NONE;
        if (!is_mdu) begin
            case (bus.i_alu_op)
                ALU_OP_BRANCH: begin
                    case (bus.i_f3)
                        F3_BLT, F3_BGE:   bus.o_alu_ctl = ALU_CTL_SLT;
                        F3_BLTU, F3_BGEU: bus.o_alu_ctl = ALU_CTL_SLTU;
                        default:          bus.o_alu_ctl = ALU_CTL_SUB;
                    endcase
                end
                ALU_OP_R, ALU_OP_I: begin
                    case (bus.i_f3)
                        F3_ADD_SUB: bus.o_alu_ctl = ((bus.i_alu_op == ALU_OP_R) && bus.i_f7_b6)
                                                    ? ALU_CTL_SUB : ALU_CTL_ADD;
                        F3_SLL: begin
                            bus.o_alu_ctl   = ALU_CTL_SHIFT;
                            bus.o_alu_shift = ALU_SHIFT_SLL;
                        end
                        F3_SLT:  bus.o_alu_ctl = ALU_CTL_SLT;
                        F3_SLTU: bus.o_alu_ctl = ALU_CTL_SLTU;
                        F3_XOR:  bus.o_alu_ctl = ALU_CTL_XOR;
                        F3_SRL_SRA: begin
                            bus.o_alu_ctl   = ALU_CTL_SHIFT;
                            bus.o_alu_shift = bus.i_f7_b6 ? ALU_SHIFT_SRA : ALU_SHIFT_SRL;
                        end
                        F3_OR:   bus.o_alu_ctl = ALU_CTL_OR;
                        default: bus.o_alu_ctl = ALU_CTL_AND;
                    endcase
                end
                default: bus.o_alu_ctl = ALU_CTL_ADD;
            endcase
        end
    end

    assign bus.o_is_mdu = is_mdu;

    mdu_core #(.XLEN(XLEN)) u_mdu_core (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .start  (start),
        .flush  (bus.i_flush),
        .f3     (bus.i_f3),
        .rs1    (bus.i_rs1),
        .rs2    (bus.i_rs2),
        .stall  (bus.o_stall),
        .done   (bus.o_mdu_done),
        .result (bus.o_mdu_result)
    );

endmodule

// File: tb/tb_control_alu_mdu.sv
// Directed bench for control_alu_mdu: decode vectors, RV32M results/latency, flush and reset abort.
module tb_control_alu_mdu;
    import control_alu_mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    control_alu_mdu_if #(.XLEN(32)) bus ();

    control_alu_mdu #(.XLEN(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        else n_pass++;
    endtask

    task automatic decode(input string tag, input logic [2:0] op, input logic [2:0] f3,
                          input logic b6, input logic [2:0] exp_ctl, input logic [1:0] exp_sh);
        @(negedge clk);
        bus.i_alu_op = op; bus.i_f3 = f3; bus.i_f7_b6 = b6; bus.i_f7_b0 = 1'b0; bus.i_valid = 1'b1;
        #1;
        check({tag, "_ctl"}, bus.o_alu_ctl, exp_ctl);
        check({tag, "_shift"}, bus.o_alu_shift, exp_sh);
        check({tag, "_stall"}, bus.o_stall, 1'b0);
        @(posedge clk); #1;
        check({tag, "_stall_next"}, bus.o_stall, 1'b0);
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.i_alu_op = ALU_OP_R; bus.i_f3 = f3; bus.i_f7_b6 = 1'b0; bus.i_f7_b0 = 1'b1;
        bus.i_rs1 = a; bus.i_rs2 = b; bus.i_valid = 1'b1; bus.i_flush = 1'b0;
    endtask

    task automatic run_mdu(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int stalls;
        bit seen;
        @(negedge clk);
        issue(f3, a, b);
        #1;
        check({tag, "_issue_stall"}, bus.o_stall, 1'b1);
        check({tag, "_is_mdu"}, bus.o_is_mdu, 1'b1);
        check({tag, "_ctl_add"}, bus.o_alu_ctl, ALU_CTL_ADD);
        stalls = 1; lat = 0; seen = 1'b0;
        while (!seen && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (bus.o_mdu_done) begin
                seen = 1'b1;
                check({tag, "_result"}, bus.o_mdu_result, exp_res);
                check({tag, "_latency"}, lat, exp_lat);
                check({tag, "_stall_cycles"}, stalls, exp_lat);
                check({tag, "_done_stall"}, bus.o_stall, 1'b0);
            end else if (bus.o_stall) begin
                stalls++;
            end
        end
        check({tag, "_done_seen"}, seen, 1'b1);
        @(negedge clk);
        bus.i_valid = 1'b0;
        @(posedge clk); #1;
        check({tag, "_single_pulse"}, bus.o_mdu_done, 1'b0);
        check({tag, "_idle_stall"}, bus.o_stall, 1'b0);
    endtask

    initial begin
        int dones;
        bus.i_alu_op = ALU_OP_LS; bus.i_f3 = '0; bus.i_f7_b6 = 1'b0; bus.i_f7_b0 = 1'b0;
        bus.i_valid = 1'b0; bus.i_flush = 1'b0; bus.i_rs1 = '0; bus.i_rs2 = '0;

        #12;
        check("rst_stall", bus.o_stall, 1'b0);
        check("rst_done", bus.o_mdu_done, 1'b0);
        check("rst_result", bus.o_mdu_result, 32'h0);
        rst_n = 1'b1;

        decode("sra",      ALU_OP_R,      3'b101, 1'b1, ALU_CTL_SHIFT, ALU_SHIFT_SRA);
        decode("srl",      ALU_OP_I,      3'b101, 1'b0, ALU_CTL_SHIFT, ALU_SHIFT_SRL);
        decode("sll",      ALU_OP_R,      3'b001, 1'b0, ALU_CTL_SHIFT, ALU_SHIFT_SLL);
        decode("sub",      ALU_OP_R,      3'b000, 1'b1, ALU_CTL_SUB,   ALU_SHIFT_NONE);
        decode("addi",     ALU_OP_I,      3'b000, 1'b1, ALU_CTL_ADD,   ALU_SHIFT_NONE);
        decode("and",      ALU_OP_R,      3'b111, 1'b0, ALU_CTL_AND,   ALU_SHIFT_NONE);
        decode("bltu",     ALU_OP_BRANCH, 3'b110, 1'b0, ALU_CTL_SLTU,  ALU_SHIFT_NONE);
        decode("beq",      ALU_OP_BRANCH, 3'b000, 1'b0, ALU_CTL_SUB,   ALU_SHIFT_NONE);
        decode("load",     ALU_OP_LS,     3'b010, 1'b0, ALU_CTL_ADD,   ALU_SHIFT_NONE);
        @(negedge clk); bus.i_valid = 1'b0;

        run_mdu("mul",     MUL_F3,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_mdu("mul_lo",  MUL_F3,    32'h1234_5678, 32'h10,       32'h2345_6780, MUL_LAT);
        run_mdu("mulhu",   MULHU_F3,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_mdu("mulh",    MULH_F3,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
        run_mdu("mulhsu",  MULHSU_F3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
        run_mdu("div",     DIV_F3,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, DIV_LAT);
        run_mdu("rem",     REM_F3,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, DIV_LAT);
        run_mdu("divu",    DIVU_F3,   32'd100,      32'd7,         32'd14,        DIV_LAT);
        run_mdu("remu",    REMU_F3,   32'd100,      32'd7,         32'd2,         DIV_LAT);
        run_mdu("divu_z",  DIVU_F3,   32'd5,        32'd0,         32'hFFFF_FFFF, 1);
        run_mdu("remu_z",  REMU_F3,   32'd5,        32'd0,         32'd5,         1);
        run_mdu("rem_ovf", REM_F3,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        1);
        run_mdu("div_ovf", DIV_F3,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);

        // Flush in the issue cycle must not start the sequencer.
        @(negedge clk);
        issue(DIV_F3, 32'd9, 32'd3);
        bus.i_flush = 1'b1;
        #1;
        check("flush_issue_stall", bus.o_stall, 1'b0);
        @(negedge clk);
        bus.i_valid = 1'b0; bus.i_flush = 1'b0;
        #1;
        check("flush_issue_idle", bus.o_stall, 1'b0);

        // Flush ten cycles into a divide.
        @(negedge clk);
        issue(DIV_F3, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("flush_mid_busy", bus.o_stall, 1'b1);
        bus.i_flush = 1'b1;
        @(posedge clk); #1;
        check("flush_stall_drop", bus.o_stall, 1'b0);
        @(negedge clk);
        bus.i_valid = 1'b0; bus.i_flush = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.o_mdu_done) dones++;
        end
        check("flush_no_done", dones, 0);

        // Asynchronous reset ten cycles into a divide.
        @(negedge clk);
        issue(DIV_F3, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rst_mid_busy", bus.o_stall, 1'b1);
        bus.i_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_stall", bus.o_stall, 1'b0);
        check("rst_mid_done", bus.o_mdu_done, 1'b0);
        check("rst_mid_result", bus.o_mdu_result, 32'h0);
        dones = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.o_mdu_done || bus.o_stall) dones++;
        end
        check("rst_hold_quiet", dones, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.o_mdu_done) dones++;
        end
        check("rst_no_done", dones, 0);

        run_mdu("after_rst", DIVU_F3, 32'd1000, 32'd3, 32'd333, DIV_LAT);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
